// File: rtl/spram_fb.sv
// Frame-buffer memory over BANKS single-ported 16k x 16 SPRAMs with write/read arbitration,
// write starvation protection and a hardware fill engine. SpramBlock mirrors SB_SPRAM256KA behaviour.

module SpramBlock (
  input  logic        CLOCK,
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);
  logic [15:0] r_mem [16384];
  logic        w_en;

  assign w_en = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;

  // Each nibble is written only when its mask bit is set; DATAOUT holds during writes.
  always_ff @(posedge CLOCK) begin
    if (w_en) begin
      if (WREN) begin
        for (int n = 0; n < 4; n++)
          if (MASKWREN[n]) r_mem[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
      end else begin
        DATAOUT <= r_mem[ADDRESS];
      end
    end
  end
endmodule

module spram_fb #(
  parameter int                DATA_W     = 8,
  parameter int                BANKS      = 3,
  parameter int                ADDR_W     = 17,
  parameter int                STARVE_MAX = 4,
  parameter logic [DATA_W-1:0] CLR_VALUE  = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              clr_start,
  output logic              busy,
  output logic              addr_err
);
  localparam int L      = (DATA_W == 16) ? 0 : ((DATA_W == 8) ? 1 : 2);
  localparam int LANES  = 16 / DATA_W;
  localparam int NIB    = DATA_W / 4;
  localparam int LANE_W = (L > 0) ? L : 1;
  localparam int BANK_W = ADDR_W - L - 14;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            r_state;
  logic [13:0]       r_clrCnt;
  logic [7:0]        r_starveCnt;
  logic              r_addrErr;
  logic              r_cmdWe, r_cmdRd, r_cmdClr, r_cmdErr;
  logic [13:0]       r_cmdWord;
  logic [BANK_W-1:0] r_cmdBank;
  logic [LANE_W-1:0] r_cmdLane;
  logic [3:0]        r_cmdMask;
  logic [15:0]       r_cmdData;
  logic              r_rdPend, r_rdErr;
  logic [BANK_W-1:0] r_rdBank;
  logic [LANE_W-1:0] r_rdLane;
  logic [DATA_W-1:0] r_rdData;
  logic              r_rdDataValid;

  logic              w_starve, w_arbOn, w_wrGo, w_rdGo, w_reqErr;
  logic [ADDR_W-1:0] w_reqAddr;
  logic [13:0]       w_reqWord;
  logic [BANK_W-1:0] w_reqBank;
  logic [LANE_W-1:0] w_reqLane;
  logic [15:0]       w_fill, w_sramData, w_rdWord;
  logic [3:0]        w_sramMask;
  logic [15:0]       w_bankOut [BANKS];

  function automatic logic [3:0] laneMask(input logic [LANE_W-1:0] lane);
    logic [3:0] base;
    base = 4'((1 << NIB) - 1);
    return base << (NIB * int'(lane));
  endfunction

  assign w_starve  = r_starveCnt >= 8'(STARVE_MAX);
  assign w_arbOn   = (r_state == IDLE) && !clr_start;
  assign rd_ready  = w_arbOn && !(wr_valid && w_starve);
  assign wr_ready  = w_arbOn && (!rd_valid || w_starve);
  assign w_wrGo    = wr_valid && wr_ready;
  assign w_rdGo    = rd_valid && rd_ready;
  assign w_reqAddr = w_wrGo ? wr_addr : rd_addr;
  assign w_reqWord = w_reqAddr[L+13:L];
  assign w_reqBank = w_reqAddr[ADDR_W-1:L+14];
  assign w_reqErr  = int'(w_reqBank) >= BANKS;

  if (L > 0) begin : g_lane
    assign w_reqLane = w_reqAddr[L-1:0];
  end else begin : g_noLane
    assign w_reqLane = 1'b0;
  end

  // Accepted requests and clear steps are registered into one command slot feeding all SPRAMs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_clrCnt    <= '0;
      r_starveCnt <= '0;
      r_addrErr   <= 1'b0;
      r_cmdWe     <= 1'b0;
      r_cmdRd     <= 1'b0;
      r_cmdClr    <= 1'b0;
      r_cmdErr    <= 1'b0;
      r_cmdWord   <= '0;
      r_cmdBank   <= '0;
      r_cmdLane   <= '0;
      r_cmdMask   <= '0;
      r_cmdData   <= '0;
    end else begin
      r_cmdWe  <= 1'b0;
      r_cmdRd  <= 1'b0;
      r_cmdClr <= 1'b0;
      if (!wr_valid || w_wrGo) r_starveCnt <= '0;
      else if (w_rdGo && r_starveCnt != 8'hFF) r_starveCnt <= r_starveCnt + 8'd1;
      if ((w_wrGo || w_rdGo) && w_reqErr) r_addrErr <= 1'b1;
      case (r_state)
        IDLE: begin
          if (clr_start) begin
            r_state  <= CLEAR;
            r_clrCnt <= '0;
          end else if (w_wrGo || w_rdGo) begin
            r_cmdWe   <= w_wrGo && !w_reqErr;
            r_cmdRd   <= w_rdGo;
            r_cmdErr  <= w_reqErr;
            r_cmdWord <= w_reqWord;
            r_cmdBank <= w_reqBank;
            r_cmdLane <= w_reqLane;
            r_cmdMask <= laneMask(w_reqLane);
            r_cmdData <= {LANES{wr_data}};
          end
        end
        CLEAR: begin
          r_cmdClr  <= 1'b1;
          r_cmdWord <= r_clrCnt;
          r_clrCnt  <= r_clrCnt + 14'd1;
          if (r_clrCnt == 14'h3FFF) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = (r_state == CLEAR);
  assign addr_err   = r_addrErr;
  assign w_fill     = {LANES{CLR_VALUE}};
  assign w_sramData = r_cmdClr ? w_fill : r_cmdData;
  assign w_sramMask = r_cmdClr ? 4'hF : r_cmdMask;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic w_wren;
    assign w_wren = r_cmdClr || (r_cmdWe && r_cmdBank == BANK_W'(b));
    SpramBlock u_spram (
      .CLOCK(clk), .ADDRESS(r_cmdWord), .DATAIN(w_sramData), .MASKWREN(w_sramMask),
      .WREN(w_wren), .CHIPSELECT(1'b1), .STANDBY(1'b0), .SLEEP(1'b0), .POWEROFF(1'b1),
      .DATAOUT(w_bankOut[b])
    );
  end

  always_comb begin
    w_rdWord = '0;
    for (int b = 0; b < BANKS; b++)
      if (r_rdBank == BANK_W'(b)) w_rdWord = w_bankOut[b];
  end

  // Bank/lane of a read travel one stage behind the SPRAM access to pick the lane from DATAOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdPend      <= 1'b0;
      r_rdErr       <= 1'b0;
      r_rdBank      <= '0;
      r_rdLane      <= '0;
      r_rdData      <= '0;
      r_rdDataValid <= 1'b0;
    end else begin
      r_rdPend      <= r_cmdRd;
      r_rdErr       <= r_cmdErr;
      r_rdBank      <= r_cmdBank;
      r_rdLane      <= r_cmdLane;
      r_rdDataValid <= r_rdPend;
      if (r_rdPend) r_rdData <= r_rdErr ? '0 : w_rdWord[int'(r_rdLane)*DATA_W +: DATA_W];
    end
  end

  assign rd_data       = r_rdData;
  assign rd_data_valid = r_rdDataValid;
endmodule
